// File: rtl/saph_num_pack_stream.sv
// Streaming bit packer: concatenates variable-width fields LSB-first into
// fixed-width words; a flush closes the record with a zero-padded last word.
module saph_num_pack_stream #(
  parameter  int in_width  = 8,
  parameter  int out_width = 32,
  localparam int len_w     = $clog2(in_width + 1),
  localparam int bits_w    = $clog2(out_width + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [in_width-1:0]  in_data,
  input  logic [len_w-1:0]     in_len,
  input  logic                 in_flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [out_width-1:0] out_data,
  output logic [bits_w-1:0]    out_bits,
  output logic                 out_last
);

  localparam int acc_w = out_width + in_width;
  // cnt never exceeds acc_w-1, so clog2(acc_w) bits are enough.
  localparam int cnt_w = $clog2(acc_w);
  localparam logic [cnt_w-1:0] word_cnt = cnt_w'(out_width);

  logic [acc_w-1:0] acc;
  logic [cnt_w-1:0] cnt;
  logic             flush_pend;

  logic [len_w-1:0] len_c;
  logic [acc_w-1:0] field_bits;
  logic [acc_w-1:0] part_word;
  logic             accept;
  logic             slot_free;
  logic             full_emit;
  logic             part_emit;
  logic             last_full;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    len_c      = (in_len > len_w'(in_width)) ? len_w'(in_width) : in_len;
    field_bits = (acc_w'(in_data) & ((acc_w'(1) << len_c) - acc_w'(1))) << cnt;
    part_word  = acc & ((acc_w'(1) << cnt) - acc_w'(1));
  end

  assign in_ready  = !flush_pend && (cnt < word_cnt);
  assign accept    = in_valid && in_ready;
  assign slot_free = !out_valid || out_ready;
  assign full_emit = slot_free && (cnt >= word_cnt);
  assign part_emit = slot_free && flush_pend && (cnt < word_cnt);
  // A full word closes the record only when it consumes exactly the pending bits.
  assign last_full = flush_pend && (cnt == word_cnt);

  // Accept and either emit are mutually exclusive: in_ready excludes both
  // cnt >= out_width and a pending flush.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      cnt        <= '0;
      flush_pend <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_bits   <= '0;
      out_last   <= 1'b0;
    end else begin
      if (accept) begin
        acc        <= acc | field_bits;
        cnt        <= cnt + cnt_w'(len_c);
        flush_pend <= in_flush;
      end else if (full_emit) begin
        acc <= acc >> out_width;
        if (last_full) begin
          cnt        <= '0;
          flush_pend <= 1'b0;
        end else begin
          cnt <= cnt - word_cnt;
        end
      end else if (part_emit) begin
        acc        <= '0;
        cnt        <= '0;
        flush_pend <= 1'b0;
      end

      if (full_emit) begin
        out_valid <= 1'b1;
        out_data  <= acc[out_width-1:0];
        out_bits  <= bits_w'(out_width);
        out_last  <= last_full;
      end else if (part_emit) begin
        out_valid <= 1'b1;
        out_data  <= part_word[out_width-1:0];
        out_bits  <= bits_w'(cnt);
        out_last  <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_saph_num_pack_stream.sv
// Self-checking bench for saph_num_pack_stream: directed vectors, corner
// sequences and randomized traffic against a bit-queue reference model.
module tb_saph_num_pack_stream;

  localparam int OW = 32;

  typedef struct packed {
    logic [3:0] len;
    logic [7:0] data;
    logic       flush;
  } field_t;

  typedef struct packed {
    logic [31:0] data;
    logic [5:0]  bits;
    logic        last;
  } word_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [3:0]  in_len;
  logic        in_flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_bits;
  logic        out_last;

  int    n_checks = 0;
  int    n_err    = 0;
  bit    bitq[$];
  word_t exp_q[$];
  word_t cap[$];
  word_t mon_w;
  bit    rnd_done;

  saph_num_pack_stream #(.in_width(8), .out_width(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_len   (in_len),
    .in_flush (in_flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_bits (out_bits),
    .out_last (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a plain bit stream cut into words by the record rules.
  function automatic void push_word(input int n, input bit last);
    word_t w;
    w = '0;
    for (int i = 0; i < n; i++) w.data[i] = bitq.pop_front();
    w.bits = 6'(n);
    w.last = last;
    exp_q.push_back(w);
  endfunction

  function automatic void model_accept(input logic [3:0] len, input logic [7:0] data,
                                       input logic flush);
    int n;
    n = (len > 4'd8) ? 8 : int'(len);
    for (int i = 0; i < n; i++) bitq.push_back(data[i]);
    if (flush) begin
      while (bitq.size() > OW) push_word(OW, 1'b0);
      push_word(bitq.size(), 1'b1);
    end else begin
      while (bitq.size() >= OW) push_word(OW, 1'b0);
    end
  endfunction

  // Sample handshakes on the falling edge; they complete at the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        mon_w = '{data: out_data, bits: out_bits, last: out_last};
        cap.push_back(mon_w);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL sb_unexpected: got %h expected no word", mon_w);
        end else begin
          check("sb_word", 64'(mon_w), 64'(exp_q.pop_front()));
        end
      end
      if (in_valid && in_ready) model_accept(in_len, in_data, in_flush);
    end
  end

  task automatic send(input logic [3:0] len, input logic [7:0] data, input logic flush);
    bit got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_len   = len;
    in_data  = data;
    in_flush = flush;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_flush = 1'b0;
    if (!got) begin
      n_checks++;
      n_err++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 300 cycles");
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 300; t++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    @(posedge clk);
    #1;
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  field_t ftbl[25];
  word_t  wtbl[7];
  logic [31:0] hold_d;
  int          changes;

  initial begin
    ftbl = '{
      '{4'd4, 8'hF1, 1'b0}, '{4'd4, 8'hF2, 1'b0}, '{4'd4, 8'hF3, 1'b0}, '{4'd4, 8'hF4, 1'b0},
      '{4'd4, 8'hF5, 1'b0}, '{4'd4, 8'hF6, 1'b0}, '{4'd4, 8'hF7, 1'b0}, '{4'd4, 8'hF8, 1'b0},
      '{4'd12, 8'h5A, 1'b0}, '{4'd12, 8'hA5, 1'b0}, '{4'd8, 8'h3C, 1'b0}, '{4'd12, 8'hC3, 1'b0},
      '{4'd5, 8'h1F, 1'b0}, '{4'd3, 8'h02, 1'b1},
      '{4'd7, 8'h7F, 1'b0}, '{4'd7, 8'h7F, 1'b0}, '{4'd7, 8'h7F, 1'b0}, '{4'd7, 8'h7F, 1'b0},
      '{4'd7, 8'h7F, 1'b0}, '{4'd0, 8'h00, 1'b1},
      '{4'd0, 8'hFF, 1'b1},
      '{4'd8, 8'hEF, 1'b0}, '{4'd8, 8'hBE, 1'b0}, '{4'd8, 8'hAD, 1'b0}, '{4'd8, 8'hDE, 1'b1}
    };
    wtbl = '{
      '{32'h87654321, 6'd32, 1'b0},
      '{32'hC33CA55A, 6'd32, 1'b0},
      '{32'h0000005F, 6'd8,  1'b1},
      '{32'hFFFFFFFF, 6'd32, 1'b0},
      '{32'h00000007, 6'd3,  1'b1},
      '{32'h00000000, 6'd0,  1'b1},
      '{32'hDEADBEEF, 6'd32, 1'b1}
    };

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_len    = '0;
    in_flush  = 1'b0;
    out_ready = 1'b1;
    rnd_done  = 1'b0;
    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_bits",  64'(out_bits),  64'd0);
    check("rst_out_last",  64'(out_last),  64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Four bytes fill one word; in_ready drops for exactly the emit cycle.
    send(4'd8, 8'h11, 1'b0);
    send(4'd8, 8'h22, 1'b0);
    send(4'd8, 8'h33, 1'b0);
    send(4'd8, 8'h44, 1'b0);
    check("fill_in_ready_low", 64'(in_ready),  64'd0);
    check("fill_no_word_yet",  64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("fill_out_valid", 64'(out_valid), 64'd1);
    check("fill_out_data",  64'(out_data),  64'h44332211);
    check("fill_out_bits",  64'(out_bits),  64'd32);
    check("fill_out_last",  64'(out_last),  64'd0);
    check("fill_in_ready",  64'(in_ready),  64'd1);
    drain();

    // Directed vector table: masking, clamp, flush, straddle, empty flush.
    cap.delete();
    for (int i = 0; i < 25; i++) send(ftbl[i].len, ftbl[i].data, ftbl[i].flush);
    drain();
    check("tbl_count", 64'(cap.size()), 64'd7);
    for (int i = 0; i < 7; i++) begin
      if (i < cap.size()) check($sformatf("tbl_word_%0d", i), 64'(cap[i]), 64'(wtbl[i]));
    end

    // Partial flush: in_ready stays low until the last word is emitted.
    send(4'd5, 8'h1F, 1'b0);
    send(4'd3, 8'h02, 1'b1);
    check("flush_in_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    check("flush_in_ready_back", 64'(in_ready),  64'd1);
    check("flush_out_valid",     64'(out_valid), 64'd1);
    check("flush_out_data",      64'(out_data),  64'h5F);
    check("flush_out_bits",      64'(out_bits),  64'd8);
    check("flush_out_last",      64'(out_last),  64'd1);
    drain();

    // Backpressure: first word holds, input stalls, nothing lost on release.
    cap.delete();
    out_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 12; i++) send(4'd8, 8'(8'h11 * i), 1'b0);
      end
      begin
        repeat (12) @(posedge clk);
        #1;
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_out_data",  64'(out_data),  64'h44332211);
        check("bp_in_ready",  64'(in_ready),  64'd0);
        hold_d  = out_data;
        changes = 0;
        repeat (10) begin
          @(negedge clk);
          if (out_data !== hold_d || out_valid !== 1'b1 || out_bits !== 6'd32 ||
              out_last !== 1'b0) changes++;
        end
        check("bp_hold_stable", 64'(changes), 64'd0);
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", 64'(cap.size()), 64'd3);
    if (cap.size() == 3) begin
      check("bp_word0", 64'(cap[0].data), 64'h44332211);
      check("bp_word1", 64'(cap[1].data), 64'h88776655);
      check("bp_word2", 64'(cap[2].data), 64'hCCBBAA99);
    end

    // Asynchronous reset with a held word and 20 partial bits.
    out_ready = 1'b0;
    send(4'd8, 8'h01, 1'b0);
    send(4'd8, 8'h02, 1'b0);
    send(4'd8, 8'h03, 1'b0);
    send(4'd8, 8'h04, 1'b0);
    send(4'd8, 8'h05, 1'b0);
    send(4'd8, 8'h06, 1'b0);
    send(4'd4, 8'h07, 1'b0);
    check("pre_rst_out_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    bitq.delete();
    exp_q.delete();
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_in_ready",  64'(in_ready),  64'd1);
    check("async_rst_out_data",  64'(out_data),  64'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    cap.delete();
    send(4'd8, 8'hA1, 1'b0);
    send(4'd8, 8'hA2, 1'b0);
    send(4'd8, 8'hA3, 1'b0);
    send(4'd8, 8'hA4, 1'b0);
    drain();
    check("post_rst_count", 64'(cap.size()), 64'd1);
    if (cap.size() == 1) check("post_rst_word", 64'(cap[0].data), 64'hA4A3A2A1);

    // Randomized traffic with random backpressure against the model.
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clk);
            #1;
          end
          send(4'($urandom_range(0, 10)), 8'($urandom), ($urandom_range(0, 5) == 0));
        end
        send(4'd0, 8'h00, 1'b1);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();
    check("rnd_model_empty", 64'(bitq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/saph_num_pack_stream.md
Name: saph_num_pack_stream

Overview:
Streaming bit packer, the write-side counterpart of the variable-range field unpack logic. Accepts one variable-width number per handshake and concatenates the fields LSB-first into fixed-width output words. A flush marker closes a record and emits a zero-padded partial word. Sits in front of buffers and memory writers that store packed attribute and texture data.

Parameters:
in_width, 8, maximum field width in bits; range 2..out_width.
out_width, 32, output word width in bits; range 2 or more.
len_w (localparam), $clog2(in_width+1), width of in_len.
bits_w (localparam), $clog2(out_width+1), width of out_bits.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  field valid.
in_ready  out  1  field accepted when in_valid && in_ready.
in_data  in  in_width  field value; bits at and above in_len are ignored.
in_len  in  len_w  field length, 0..in_width.
in_flush  in  1  field is the last of its record.
out_valid  out  1  output word valid.
out_ready  in  1  consumer ready.
out_data  out  out_width  packed word; first field at bit 0.
out_bits  out  bits_w  number of valid bits in out_data: out_width, or fewer on the last word.
out_last  out  1  word closes a record.

Behaviour:
- State:
  - acc: (out_width+in_width)-bit accumulator.
  - cnt: valid bit count of acc.
  - flush_pend: flag.
  - Output register: out_data, out_bits, out_last, out_valid.
- Reset (rst_n low, asynchronous):
  - acc=0, cnt=0, flush_pend=0.
  - out_valid=0, out_data=0, out_bits=0, out_last=0.
  - Reset mid-operation discards all partial bits and any held word without emitting them.
- in_ready is combinational: !flush_pend && cnt < out_width. It is 1 during reset.
- Length clamp: an in_len above in_width is treated as in_width.
- Field masking: in_data is masked to the low in_len bits. in_len=0 adds no bits but still honours in_flush.
- Accept, when in_valid && in_ready:
  - acc |= masked_data << cnt.
  - cnt += len.
  - flush_pend <= in_flush.
  - Overflow is impossible, because cnt < out_width implies cnt+len <= out_width+in_width-1.
- Output slot free: the slot is free when !out_valid || out_ready.
- Word emit, when the slot is free and cnt >= out_width:
  - If !flush_pend, or flush_pend && cnt > out_width:
    - out_data=acc[out_width-1:0], out_bits=out_width, out_last=0.
    - acc >>= out_width, cnt -= out_width.
    - flush_pend is unchanged.
  - If flush_pend && cnt == out_width:
    - Same word, but out_last=1.
    - cnt=0, flush_pend=0.
- Partial emit, when the slot is free, flush_pend, and cnt < out_width:
  - out_data = acc with bits at and above cnt forced to 0.
  - out_bits=cnt, out_last=1, acc=0, cnt=0, flush_pend=0.
  - cnt=0 gives an empty last word: out_data=0, out_bits=0, out_last=1.
- Accept and emit are mutually exclusive in a cycle, because in_ready requires cnt < out_width and !flush_pend.
- Throughput: at most one bubble on the input per emitted full word.
- Latency: a field completing a word produces out_valid on the next cycle, if the slot is free.
- When the slot is free and nothing is emitted, out_valid drops after a handshake.
- While out_valid && !out_ready, out_data, out_bits and out_last hold stable. Input continues to be accepted until cnt >= out_width.
- Ordering: fields are never reordered or dropped. Every record ends with exactly one word with out_last=1.

Test Plan:
1. Defaults. Fields len 8: 0x11, 0x22, 0x33, 0x44, no flush -> one word 0x44332211, out_bits=32, out_last=0. in_ready=0 for one cycle after the 4th accept.
2. Eight fields len 4, values 1..8, with in_data upper bits set to 0xF (e.g. 0xF1) -> 0x87654321. Upper bits are masked. A field with in_len=12 behaves as len 8.
3. Fields (len 5, 0x1F) then (len 3, 0x2, flush) -> out_data=0x0000005F, out_bits=8, out_last=1. in_ready stays 0 until the emit, then returns to 1.
4. Straddle: five fields len 7, data 0x7F -> 0xFFFFFFFF, bits 32, last 0. Then (len 0, flush) -> 0x00000007, bits 3, last 1. Separately, flush on an empty accumulator -> out_data=0, bits 0, last 1.
5. Backpressure: hold out_ready=0 while streaming 12 len-8 fields:
   - The first word holds stable.
   - in_ready falls once cnt reaches 32.
   - Releasing out_ready yields 0x44332211, 0x88776655, 0xCCBBAA99 in order, with no loss.
6. Reset mid-operation: assert rst_n low asynchronously with cnt=20 and out_valid=1 -> out_valid=0 without waiting for a clock edge. After release, the next word contains only post-reset fields.
